// File: rtl/pe_pkg.sv
// Shared types and constants for the convolution PE control FSM.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        PSUM,
        HOLD,
        DONE
    } pe_state_e;

    localparam int unsigned KSIZE_DEFAULT = 9;

endpackage : pe_pkg

// File: rtl/pe_fsm.sv
// Control FSM for one convolution PE: sequences kernel-tap reads over the
// latched input/output channel groups and flags partial-sum results.
module pe_fsm
    import pe_pkg::*;
#(
    parameter int unsigned KSIZE = KSIZE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_conv,
    input  logic       start_again,
    input  logic [1:0] cfg_ci,
    input  logic [1:0] cfg_co,
    output logic       ifm_read,
    output logic       wgt_read,
    output logic       p_valid_output,
    output logic       last_chanel_output,
    output logic       end_conv
);

    localparam int unsigned TAP_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KSIZE - 1);

    pe_state_e        state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [1:0]       ci_q, ci_d;
    logic [1:0]       co_q, co_d;
    logic [1:0]       ci_lim_q, ci_lim_d;
    logic [1:0]       co_lim_q, co_lim_d;

    // State, counter and latched-configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            ci_q     <= '0;
            co_q     <= '0;
            ci_lim_q <= '0;
            co_lim_q <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            ci_q     <= ci_d;
            co_q     <= co_d;
            ci_lim_q <= ci_lim_d;
            co_lim_q <= co_lim_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        ci_d     = ci_q;
        co_d     = co_q;
        ci_lim_d = ci_lim_q;
        co_lim_d = co_lim_q;
        case (state_q)
            IDLE: begin
                if (start_conv) begin
                    ci_lim_d = cfg_ci;
                    co_lim_d = cfg_co;
                    tap_d    = '0;
                    ci_d     = '0;
                    co_d     = '0;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    state_d = PSUM;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            PSUM: begin
                if (ci_q != ci_lim_q) begin
                    ci_d    = ci_q + 1'b1;
                    state_d = COMPUTE;
                end else if (co_q != co_lim_q) begin
                    ci_d    = '0;
                    co_d    = co_q + 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = DONE;
                end
            end
            HOLD: begin
                if (start_again) begin
                    state_d = COMPUTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode from state and counters only.
    always_comb begin
        ifm_read           = (state_q == COMPUTE);
        wgt_read           = (state_q == COMPUTE);
        p_valid_output     = (state_q == PSUM);
        last_chanel_output = (state_q == PSUM) && (ci_q == ci_lim_q);
        end_conv           = (state_q == DONE);
    end

endmodule : pe_fsm

// File: tb/tb_pe_fsm.sv
// Directed self-checking bench for pe_fsm with KSIZE = 9.
module tb_pe_fsm;
    import pe_pkg::*;

    localparam int KS = 9;
    localparam int P  = KS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_conv = 1'b0;
    logic       start_again = 1'b0;
    logic [1:0] cfg_ci = 2'd0;
    logic [1:0] cfg_co = 2'd0;
    logic       ifm_read, wgt_read, p_valid_output, last_chanel_output, end_conv;

    int n_cmp = 0;
    int n_bad = 0;

    pe_fsm #(.KSIZE(KS)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_conv         (start_conv),
        .start_again        (start_again),
        .cfg_ci             (cfg_ci),
        .cfg_co             (cfg_co),
        .ifm_read           (ifm_read),
        .wgt_read           (wgt_read),
        .p_valid_output     (p_valid_output),
        .last_chanel_output (last_chanel_output),
        .end_conv           (end_conv)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {ifm_read, wgt_read, p_valid_output, last_chanel_output, end_conv};
    endfunction

    // Expected {ifm,wgt,pv,last,end} for cycle k (1-based) of one co group
    // with ci+1 input groups; cycle after the group is DONE (last) or HOLD.
    function automatic logic [4:0] exp_grp(int k, int ci, bit last);
        int total;
        total = (ci + 1) * P;
        if (k >= 1 && k <= total) begin
            if (((k - 1) % P) < KS) return 5'b11000;
            return (((k - 1) / P) == ci) ? 5'b00110 : 5'b00100;
        end
        if (k == total + 1) return last ? 5'b00001 : 5'b00000;
        return 5'b00000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_conv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b00000 || dut.state_q !== IDLE) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: outputs=%b state=%0d, required 00000 state=%0d",
                         i, obs(), dut.state_q, IDLE);
            end
        end
        rst = 1'b0;
        start_conv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_release cyc%0d: outputs=%b, required 00000", i, obs());
            end
        end
    endtask

    task automatic test_basic();
        cfg_ci = 2'd1;
        cfg_co = 2'd0;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            n_cmp++;
            if (obs() !== exp_grp(k, 1, 1'b1)) begin
                n_bad++;
                $display("FAIL basic cyc%0d: outputs=%b, required %b", k, obs(), exp_grp(k, 1, 1'b1));
            end
            if (k < 22) tick();
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL basic_idle: state=%0d, required %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_multi_co();
        cfg_ci = 2'd1;
        cfg_co = 2'd2;
        start_conv = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            for (int k = 1; k <= 21; k++) begin
                n_cmp++;
                if (obs() !== exp_grp(k, 1, g == 2)) begin
                    n_bad++;
                    $display("FAIL multi_co g%0d cyc%0d: outputs=%b, required %b",
                             g, k, obs(), exp_grp(k, 1, g == 2));
                end
                if (g == 0 && k == 1) start_conv = 1'b0;
                tick();
            end
            if (g < 2) begin
                for (int h = 0; h < 5; h++) begin
                    n_cmp++;
                    if (obs() !== 5'b00000 || dut.state_q !== HOLD) begin
                        n_bad++;
                        $display("FAIL multi_co_hold g%0d h%0d: outputs=%b state=%0d, required 00000 state=%0d",
                                 g, h, obs(), dut.state_q, HOLD);
                    end
                    tick();
                end
                start_again = 1'b1;
                tick();
                start_again = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs() !== 5'b00000 || dut.state_q !== IDLE) begin
                n_bad++;
                $display("FAIL multi_co_idle cyc%0d: outputs=%b state=%0d, required 00000 state=%0d",
                         i, obs(), dut.state_q, IDLE);
            end
            tick();
        end
    endtask

    task automatic test_cfg_stability();
        int reads = 0;
        int valids = 0;
        cfg_ci = 2'd2;
        cfg_co = 2'd0;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        for (int k = 1; k <= 3 * P + 2; k++) begin
            if (k == 3) begin
                cfg_ci = 2'd0;
                cfg_co = 2'd3;
            end
            reads  += int'(ifm_read);
            valids += int'(p_valid_output);
            n_cmp++;
            if (obs() !== exp_grp(k, 2, 1'b1)) begin
                n_bad++;
                $display("FAIL cfg_stab cyc%0d: outputs=%b, required %b", k, obs(), exp_grp(k, 2, 1'b1));
            end
            tick();
        end
        n_cmp++;
        if (reads != 27 || valids != 3) begin
            n_bad++;
            $display("FAIL cfg_stab_counts: reads=%0d valids=%0d, required 27 and 3", reads, valids);
        end
    endtask

    task automatic test_ignored();
        cfg_ci = 2'd0;
        cfg_co = 2'd0;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            start_again = (k >= 2 && k <= 5);
            start_conv  = (k == 11);
            n_cmp++;
            if (obs() !== exp_grp(k, 0, 1'b1)) begin
                n_bad++;
                $display("FAIL ignored cyc%0d: outputs=%b, required %b", k, obs(), exp_grp(k, 0, 1'b1));
            end
            tick();
        end
        start_again = 1'b0;
        start_conv = 1'b0;
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL ignored_idle: state=%0d, required %0d", dut.state_q, IDLE);
        end
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        n_cmp++;
        if (obs() !== 5'b11000) begin
            n_bad++;
            $display("FAIL ignored_restart: outputs=%b, required 11000", obs());
        end
        for (int k = 2; k <= 12; k++) tick();
    endtask

    task automatic test_abort();
        int ends = 0;
        int valids = 0;
        cfg_ci = 2'd3;
        cfg_co = 2'd3;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (obs() !== 5'b11000) begin
                n_bad++;
                $display("FAIL abort_pre cyc%0d: outputs=%b, required 11000", k, obs());
            end
            if (k < 5) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs() !== 5'b00000 || dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL abort_reset: outputs=%b state=%0d, required 00000 state=%0d",
                     obs(), dut.state_q, IDLE);
        end
        for (int i = 0; i < 200; i++) begin
            ends   += int'(end_conv);
            valids += int'(p_valid_output);
            tick();
        end
        n_cmp++;
        if (ends != 0 || valids != 0) begin
            n_bad++;
            $display("FAIL abort_after: end_conv=%0d p_valid=%0d pulses, required 0 and 0", ends, valids);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_co();
        test_cfg_stability();
        test_ignored();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pe_fsm

// File: doc/pe_fsm.md
# pe_fsm

Control FSM for one convolution processing element (PE). On a start command it sequences kernel-tap reads of input feature map and weight data over a configurable number of input- and output-channel groups, and flags partial-sum and last-channel results to the accumulator. It signals completion of the whole convolution. It sits between the convolution-level controller (start/config) and the PE datapath (MAC array and accumulator).

## Interface
- `KSIZE`, default 9: kernel taps (MAC cycles) per input-channel group; legal range ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_conv`  in  1  begin a convolution; sampled only in IDLE.
- `start_again`  in  1  resume with the next output-channel group; sampled only in HOLD.
- `cfg_ci`  in  2  input-channel groups minus 1 (1–4 groups).
- `cfg_co`  in  2  output-channel groups minus 1 (1–4 groups).
- `ifm_read`  out  1  read one input-feature-map word this cycle.
- `wgt_read`  out  1  read one weight word this cycle.
- `p_valid_output`  out  1  accumulator partial sum is valid this cycle.
- `last_chanel_output`  out  1  the current partial sum is for the last input-channel group, so it is the final output-channel result.
- `end_conv`  out  1  one-cycle pulse when the convolution is complete.

## Operation
- States: IDLE, COMPUTE, PSUM, HOLD, DONE.
- **IDLE:** all outputs 0.
  - If `start_conv`=1: latch `cfg_ci` and `cfg_co`, clear `tap_cnt`, `ci_cnt` and `co_cnt`, then go to COMPUTE.
- **COMPUTE:** `ifm_read`=`wgt_read`=1. `tap_cnt` increments every cycle.
  - When `tap_cnt`==KSIZE-1: clear `tap_cnt` and go to PSUM.
- **PSUM** (lasts 1 cycle): `p_valid_output`=1. `last_chanel_output`=1 iff `ci_cnt`==latched ci.
  - If not the last ci group: increment `ci_cnt`, go to COMPUTE.
  - Else if `co_cnt`≠latched co: clear `ci_cnt`, increment `co_cnt`, go to HOLD.
  - Else go to DONE.
- **HOLD:** all outputs 0. Wait for `start_again`=1, then go to COMPUTE.
- **DONE** (lasts 1 cycle): `end_conv`=1, then go to IDLE.
- Config changes after the latch edge have no effect until the next `start_conv` accepted in IDLE.
- Outputs are Moore, decoded from the state register and counters, so no output ever depends combinationally on an input.

## Timing
- Reset: state=IDLE and all counters 0. Every output is 0 in the cycle after a reset edge.
- Reset mid-operation aborts the run immediately: no `end_conv` and no `p_valid_output` is emitted.
- `start_conv` accepted at edge E: `ifm_read`/`wgt_read` are high from the cycle after E, for KSIZE consecutive cycles.
- Each ci group takes KSIZE+1 cycles (KSIZE reads plus 1 PSUM cycle). Each co group takes (cfg_ci+1)·(KSIZE+1) cycles.
- Total busy cycles, excluding HOLD waits: (cfg_co+1)(cfg_ci+1)(KSIZE+1)+1 (the +1 is DONE).
- `start_conv` held high across multiple cycles is accepted once. It is ignored outside IDLE, including in the DONE cycle.
- `start_again` outside HOLD is ignored. In HOLD it is accepted on the edge it is sampled high, and COMPUTE begins the next cycle.
- `rst` and `start_conv` high together: reset wins.
- Counter widths: tap counter is $clog2(KSIZE) bits, minimum 1. ci/co counters are 2 bits and never wrap past the latched limit.

## Structure
- Shared package `pe_pkg` holds the state enum (IDLE, COMPUTE, PSUM, HOLD, DONE) and the default KSIZE constant.
- Single module with no sub-modules. Counters and next-state logic are inline.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `start_conv`=1 → all outputs 0, state IDLE; after release, outputs stay 0 until `start_conv` is accepted.
- **Basic run:** KSIZE=9, `cfg_ci`=1, `cfg_co`=0; `start_conv` pulsed 1 cycle at cycle 0 →
  - reads in cycles 1–9 and 11–19;
  - `p_valid_output` at cycle 10 (`last_chanel_output`=0);
  - `p_valid_output` and `last_chanel_output` both 1 at cycle 20;
  - `end_conv` at cycle 21;
  - IDLE at cycle 22.
- **Multi-co run:** `cfg_ci`=1, `cfg_co`=2, `start_conv` high for 2 cycles →
  - exactly one run starts;
  - the FSM enters HOLD at cycle 21 and stays there with outputs 0 while `start_again`=0;
  - each `start_again` pulse produces another 20-cycle group;
  - `end_conv` follows the third group.
- **Config stability:** change `cfg_ci`/`cfg_co` mid-run → read and valid counts still match the values latched at start.
- **Ignored inputs:** `start_again` during COMPUTE, and `start_conv` during DONE → no effect. The FSM returns to IDLE and needs a fresh `start_conv`.
- **Abort:** assert `rst` in cycle 5 of COMPUTE → outputs 0 next cycle, and no `end_conv` is ever emitted for that run.
